fft_input_expander: RTL and testbench



---
 rtl/fft_pkg.sv | 21 ++
 rtl/stream_skid_buf.sv | 87 ++++++++
 rtl/fft_input_expander.sv | 68 ++++++
 tb/tb_fft_input_expander.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions.
// Holds the sample/word/index widths and matching typedefs used by the
// front-end expander and the rest of the FFT datapath.
package fft_pkg;

  localparam int SAMPLE_W = 16;               // external sample width (Q1.15)
  localparam int WORD_W   = 32;               // internal working word width
  localparam int FFT_N    = 16;               // frame length (power of two)
  localparam int IDX_W    = $clog2(FFT_N);    // frame index width

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [IDX_W-1:0]    idx_t;

  // Place a sample in the upper half of a working word, low bits zero.
  // Truncating the word by (WORD_W-SAMPLE_W) gives the sample back unchanged.
  function automatic word_t widen(sample_t s);
    return word_t'(s) << (WORD_W - SAMPLE_W);
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready skid buffer (output register + skid register).
// Keeps one transfer per cycle under backpressure with a registered s_ready.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   clr                synchronous flush of both entries
//   s_valid/s_ready    upstream handshake, s_data payload in
//   m_valid/m_ready    downstream handshake, m_data payload out
module stream_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  logic         out_valid_q, out_valid_n;
  logic [W-1:0] out_data_q,  out_data_n;
  logic         skid_valid_q, skid_valid_n;
  logic [W-1:0] skid_data_q,  skid_data_n;
  logic         ready_q, ready_n;
  logic         in_fire;

  assign in_fire = s_valid && ready_q;

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through this
    // block leaves one unassigned and no latch is inferred.
    out_valid_n  = out_valid_q;
    out_data_n   = out_data_q;
    skid_valid_n = skid_valid_q;
    skid_data_n  = skid_data_q;

    if (clr) begin
      out_valid_n  = 1'b0;
      skid_valid_n = 1'b0;
    end else if (!out_valid_q || m_ready) begin
      // Output slot is empty or draining this cycle.
      if (skid_valid_q) begin
        // s_ready was low, so no input can arrive alongside the skid word.
        out_valid_n  = 1'b1;
        out_data_n   = skid_data_q;
        skid_valid_n = 1'b0;
      end else begin
        out_valid_n = in_fire;
        if (in_fire) out_data_n = s_data;
      end
    end else if (in_fire) begin
      // Output stalled: park the incoming word in the skid slot.
      skid_valid_n = 1'b1;
      skid_data_n  = s_data;
    end

    // s_ready is a registered copy of "skid slot will be empty".
    ready_n = !skid_valid_n;
  end

  // NOTE: data registers are reset too, so m_data reads 0 out of reset rather
  // than X; the cost is small for two words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      out_valid_q  <= out_valid_n;
      out_data_q   <= out_data_n;
      skid_valid_q <= skid_valid_n;
      skid_data_q  <= skid_data_n;
      ready_q      <= ready_n;
    end
  end

  assign s_ready = ready_q;
  assign m_valid = out_valid_q;
  assign m_data  = out_data_q;

endmodule

// File: rtl/fft_input_expander.sv
// FFT input front-end: widens IN_W-bit samples to OUT_W-bit working words
// (sample in the upper bits, zero low bits), buffers them through a 2-entry
// skid buffer and tags each output word with its index in an N_POINTS frame.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   clr                        synchronous flush + frame index restart
//   s_valid/s_ready/s_data     sample input stream
//   m_valid/m_ready/m_data     widened word output stream
//   m_index                    frame position of m_data
//   m_last                     m_index == N_POINTS-1
// OUT_W must be >= IN_W; N_POINTS must be a power of two, at least 2.
module fft_input_expander
  import fft_pkg::*;
#(
  parameter int IN_W     = SAMPLE_W,
  parameter int OUT_W    = WORD_W,
  parameter int N_POINTS = FFT_N,
  localparam int IX_W    = $clog2(N_POINTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic [IX_W-1:0]  m_index,
  output logic             m_last
);

  logic [OUT_W-1:0] wide_data;
  logic [IX_W-1:0]  idx_q;

  // Bit pattern preserved: no sign extension, no rounding.
  assign wide_data = OUT_W'(s_data) << (OUT_W - IN_W);

  stream_skid_buf #(
    .W (OUT_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (wide_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
  );

  // Counts output transfers; the power-of-two frame length makes the
  // natural binary wrap equal to the N_POINTS-1 -> 0 wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (clr) begin
      idx_q <= '0;
    end else if (m_valid && m_ready) begin
      idx_q <= idx_q + IX_W'(1);
    end
  end

  assign m_index = idx_q;
  assign m_last  = (idx_q == IX_W'(N_POINTS - 1));

endmodule

// File: tb/tb_fft_input_expander.sv
// Self-checking bench for fft_input_expander.
// A queue-based model (FIFO of accepted samples, capacity 2, plus a frame
// counter) predicts every output each cycle; table vectors and hand-written
// sequences add explicit expectations for the corner cases.
module tb_fft_input_expander;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic [3:0]  m_index;
  logic        m_last;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [15:0] mq[$];
  int          midx  = 0;
  bit          armed = 1'b0;

  fft_input_expander dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_index (m_index),
    .m_last  (m_last)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance the model across one clock edge using the current inputs.
  task automatic model_step();
    bit exp_rdy, ofire, ifire;
    if (clr) begin
      mq.delete();
      midx = 0;
    end else begin
      exp_rdy = armed && (mq.size() < 2);
      ofire   = (mq.size() > 0) && m_ready;
      ifire   = s_valid && exp_rdy;
      if (ofire) begin
        void'(mq.pop_front());
        midx = (midx + 1) % 16;
      end
      if (ifire) mq.push_back(s_data);
    end
    armed = 1'b1;
  endtask

  task automatic check_model();
    check("model s_ready", s_ready, armed && (mq.size() < 2));
    check("model m_valid", m_valid, mq.size() > 0);
    check("model m_index", m_index, midx);
    check("model m_last",  m_last,  midx == 15);
    if (mq.size() > 0) begin
      check("model m_data", m_data, {mq[0], 16'h0000});
      check("model roundtrip", m_data >> 16, mq[0]);
    end
  endtask

  // Drive inputs, step one clock, sample #1 after the edge.
  task automatic cycle(input logic sv, input logic [15:0] sd, input logic mr, input logic cl);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    clr     = cl;
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic model_reset();
    mq.delete();
    midx  = 0;
    armed = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " s_ready"}, s_ready, 0);
    check({tag, " m_valid"}, m_valid, 0);
    check({tag, " m_data"},  m_data,  0);
    check({tag, " m_index"}, m_index, 0);
    check({tag, " m_last"},  m_last,  0);
  endtask

  typedef struct {
    logic        sv;
    logic [15:0] sd;
    logic        mr;
    logic        exp_mv;
    logic [31:0] exp_md;
    logic [3:0]  exp_idx;
    logic        exp_sr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    // Backpressure vectors, starting from an empty buffer at index 0.
    tbl[0] = '{1'b1, 16'h1234, 1'b0, 1'b1, 32'h1234_0000, 4'd0, 1'b1};
    tbl[1] = '{1'b1, 16'hBEEF, 1'b0, 1'b1, 32'h1234_0000, 4'd0, 1'b0};
    tbl[2] = '{1'b1, 16'h7FFF, 1'b0, 1'b1, 32'h1234_0000, 4'd0, 1'b0};
    tbl[3] = '{1'b1, 16'h7FFF, 1'b1, 1'b1, 32'hBEEF_0000, 4'd1, 1'b1};
    tbl[4] = '{1'b1, 16'h7FFF, 1'b1, 1'b1, 32'h7FFF_0000, 4'd2, 1'b1};
    tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 32'h0000_0000, 4'd3, 1'b1};

    // Reset state.
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    #1;
    check("release s_ready", s_ready, 0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0);
    check("first cycle s_ready", s_ready, 1);
    check("idle m_valid", m_valid, 0);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);

    // Single sample.
    cycle(1'b1, 16'h8001, 1'b1, 1'b0);
    check("single m_valid", m_valid, 1);
    check("single m_data",  m_data,  32'h8001_0000);
    check("single m_index", m_index, 0);
    check("single m_last",  m_last,  0);
    cycle(1'b0, 16'h0, 1'b1, 1'b1);

    // 17 back-to-back samples; frame wraps after index 15.
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 16'(i), 1'b1, 1'b0);
      check("b2b m_valid", m_valid, 1);
      check("b2b m_data",  m_data,  {16'(i), 16'h0000});
      check("b2b m_index", m_index, i % 16);
      check("b2b m_last",  m_last,  i == 15);
    end

    // Backpressure table.
    cycle(1'b0, 16'h0, 1'b1, 1'b1);
    for (int r = 0; r < 6; r++) begin
      cycle(tbl[r].sv, tbl[r].sd, tbl[r].mr, 1'b0);
      check("tbl m_valid", m_valid, tbl[r].exp_mv);
      check("tbl s_ready", s_ready, tbl[r].exp_sr);
      check("tbl m_index", m_index, tbl[r].exp_idx);
      if (tbl[r].exp_mv) check("tbl m_data", m_data, tbl[r].exp_md);
    end

    // clr with both entries full at index 5.
    cycle(1'b1, 16'hA5A5, 1'b1, 1'b0);
    cycle(1'b1, 16'h5A5A, 1'b1, 1'b0);
    cycle(1'b1, 16'hC3C3, 1'b1, 1'b0);
    cycle(1'b1, 16'h3C3C, 1'b0, 1'b0);
    check("full m_index", m_index, 5);
    check("full s_ready", s_ready, 0);
    cycle(1'b1, 16'h1111, 1'b1, 1'b1);
    check("clr m_valid", m_valid, 0);
    check("clr s_ready", s_ready, 1);
    check("clr m_index", m_index, 0);
    cycle(1'b1, 16'h5555, 1'b1, 1'b0);
    check("post clr m_data",  m_data,  32'h5555_0000);
    check("post clr m_index", m_index, 0);

    // Reset mid-frame at index 9 with both entries holding data.
    for (int k = 1; k <= 9; k++) cycle(1'b1, 16'h0100 + 16'(k), 1'b1, 1'b0);
    cycle(1'b1, 16'h0AAA, 1'b0, 1'b0);
    check("pre rst m_index", m_index, 9);
    check("pre rst m_valid", m_valid, 1);
    s_valid = 1'b0;
    rst_n   = 1'b0;
    model_reset();
    #1;
    check_zero("async rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    check("rst release s_ready", s_ready, 1);
    cycle(1'b1, 16'h4321, 1'b1, 1'b0);
    check("post rst m_data",  m_data,  32'h4321_0000);
    check("post rst m_index", m_index, 0);

    // Random stream against the model.
    for (int n = 0; n < 800; n++) begin
      cycle($urandom_range(0, 3) != 0, 16'($urandom),
            $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
